// File: rtl/mem_responder_if.sv
// mem_responder_if: request/acknowledge bus between the CPU memory-address
// unit (master) and the field-extended memory responder (slave).
// Data and address vectors are numbered with bit 0 as the MSB.
interface mem_responder_if;
   logic        req;
   logic [1:0]  op;
   logic [2:0]  field;
   logic [0:11] addr;
   logic [0:11] wdata;
   logic        busy;
   logic        ack;
   logic [0:11] rdata;
   logic        carry;
   logic        nxm;
   logic        perr;

   modport master (
      output req, op, field, addr, wdata,
      input  busy, ack, rdata, carry, nxm, perr
   );

   modport slave (
      input  req, op, field, addr, wdata,
      output busy, ack, rdata, carry, nxm, perr
   );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: PDP-8/E field-extended store responder. Services read,
// write and increment requests with WAIT_STATES extra access cycles.
// Fields above MAX_FIELD read as zero, ignore writes and flag nxm.
// Optional feature macro PARITY_EN: 13-bit words with odd parity,
// checked on reads and increment reads (perr); otherwise perr is 0.
module mem_responder #(
   parameter int unsigned MAX_FIELD   = 7,
   parameter int unsigned WAIT_STATES = 0
) (
   input logic            clk,
   input logic            reset,
   mem_responder_if.slave bus
);

   localparam int unsigned DEPTH = (MAX_FIELD + 1) * 4096;
   localparam int unsigned IDX_W = $clog2(DEPTH);
`ifdef PARITY_EN
   localparam int unsigned MEM_W = 13;
`else
   localparam int unsigned MEM_W = 12;
`endif

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_MODIFY, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [1:0]  op_q, op_d;
   logic [2:0]  field_q, field_d;
   logic [0:11] addr_q, addr_d;
   logic [0:11] wdata_q, wdata_d;
   logic        busy_q, busy_d;
   logic        ack_q, ack_d;
   logic [0:11] rdata_q, rdata_d;
   logic        carry_q, carry_d;
   logic        nxm_q, nxm_d;
   logic        perr_q, perr_d;

   logic [0:MEM_W-1] mem_q [DEPTH];
   logic [IDX_W-1:0] idx;
   logic             mem_we;
   logic [0:MEM_W-1] mem_wword;
   logic [0:MEM_W-1] rd_word;
   logic [0:11]      rd_data;
   logic             rd_perr;
   logic             field_nxm;
   logic [0:11]      inc_val;

   function automatic logic [0:MEM_W-1] pack_word(input logic [0:11] d);
`ifdef PARITY_EN
      return {d, ~^d};
`else
      return d;
`endif
   endfunction

   assign idx       = IDX_W'({field_q, addr_q});
   assign field_nxm = 32'(field_q) > MAX_FIELD;
   assign rd_word   = mem_q[idx];
   assign rd_data   = rd_word[0:11];
   assign inc_val   = rdata_q + 12'd1;
`ifdef PARITY_EN
   assign rd_perr   = rd_word[12] != ~^rd_word[0:11];
`else
   assign rd_perr   = 1'b0;
`endif

   // Next-state, latched request and registered output computation
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      field_d   = field_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      busy_d    = busy_q;
      ack_d     = ack_q;
      rdata_d   = rdata_q;
      carry_d   = carry_q;
      nxm_d     = nxm_q;
      perr_d    = perr_q;
      mem_we    = 1'b0;
      mem_wword = pack_word(wdata_q);
      case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               op_d    = bus.op;
               field_d = bus.field;
               addr_d  = bus.addr;
               wdata_d = bus.wdata;
               busy_d  = 1'b1;
               cnt_d   = 4'(WAIT_STATES);
               carry_d = 1'b0;
               nxm_d   = 1'b0;
               perr_d  = 1'b0;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (field_nxm) begin
               rdata_d = '0;
               nxm_d   = 1'b1;
               carry_d = 1'b0;
               ack_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               case (op_q)
                  2'b01: begin
                     mem_we  = 1'b1;
                     rdata_d = wdata_q;
                     ack_d   = 1'b1;
                     state_d = S_DONE;
                  end
                  2'b10: begin
                     // perr is set here already; it is only observed with ack
                     rdata_d = rd_data;
                     perr_d  = rd_perr;
                     state_d = S_MODIFY;
                  end
                  default: begin
                     rdata_d = rd_data;
                     perr_d  = rd_perr;
                     ack_d   = 1'b1;
                     state_d = S_DONE;
                  end
               endcase
            end
         end
         S_MODIFY: begin
            mem_we    = 1'b1;
            mem_wword = pack_word(inc_val);
            rdata_d   = inc_val;
            carry_d   = rdata_q == 12'o7777;
            ack_d     = 1'b1;
            state_d   = S_DONE;
         end
         S_DONE: begin
            ack_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and output registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         field_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
         carry_q <= 1'b0;
         nxm_q   <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         field_q <= field_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         carry_q <= carry_d;
         nxm_q   <= nxm_d;
         perr_q  <= perr_d;
      end
   end

   // Storage array; write enable derives from reset-cleared state, so a
   // reset before the write edge cancels the write
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[idx] <= mem_wword;
   end

   assign bus.busy  = busy_q;
   assign bus.ack   = ack_q;
   assign bus.rdata = rdata_q;
   assign bus.carry = carry_q;
   assign bus.nxm   = nxm_q;
   assign bus.perr  = perr_q;

endmodule
